mem_write_buffer: RTL and testbench

Store-buffering data-memory interface placed directly downstream of the pipeline processor's memory-access port. Up to DEPTH stores are absorbed into a FIFO so the processor does not wait on a slow data memory. Loads are forwarded from the buffer on an address hit, or read from memory with a stall on a miss. The FIFO is drained to memory in the background over a req/ack handshake.

---
 rtl/mem_write_buffer.sv | 189 ++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Store-buffering data-memory interface. Stores are absorbed into a small FIFO
// and drained to memory over a req/ack handshake in the background. Loads are
// forwarded from the youngest matching buffered store, or read from memory with
// a processor stall when the address is not buffered.
module mem_write_buffer #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         W,
    input  logic                         Rd,
    input  logic [ADDR_W-1:0]            Daddress,
    input  logic [DATA_W-1:0]            Dout,
    output logic [DATA_W-1:0]            DataIn,
    output logic                         Stall,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RDONE} state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_addr_q [DEPTH];
    logic [DATA_W-1:0]   r_data_q [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic                w_full;
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_data;
    logic                w_miss;
    logic                w_push;
    logic                w_load;
    logic                w_ack;
    logic                w_pop;
    logic                w_rd_capture;
    logic                w_start_write;
    logic                w_start_read;

    // A store takes priority over a simultaneous load; the load is ignored.
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_ack  = r_mem_req && mem_ack;
    assign w_miss = Rd && !W && !w_hit;
    assign w_push = W && !w_full;
    assign w_load = Rd && !W && (w_hit || (r_state == RDONE));

    // Stall is forced low while reset is held so the processor sees a quiet port.
    assign Stall = Reset && (W ? w_full : (Rd && !w_hit && (r_state != RDONE)));

    assign DataIn    = r_data_in;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;

    // Address match over valid entries, oldest to youngest, so the youngest match wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < int'(r_count)) && (r_addr_q[r_head + PTR_W'(k)] == Daddress)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data_q[r_head + PTR_W'(k)];
            end
        end
    end

    // Controller next-state: load misses win over draining; one transaction at a time.
    always_comb begin
        w_next_state  = r_state;
        w_start_write = 1'b0;
        w_start_read  = 1'b0;
        w_pop         = 1'b0;
        w_rd_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_miss) begin
                    w_next_state = READ;
                    w_start_read = 1'b1;
                end else if (r_count != '0) begin
                    w_next_state  = WRITE;
                    w_start_write = 1'b1;
                end
            end
            WRITE: begin
                if (w_ack) begin
                    w_next_state = IDLE;
                    w_pop        = 1'b1;
                end
            end
            READ: begin
                if (w_ack) begin
                    w_next_state = RDONE;
                    w_rd_capture = 1'b1;
                end
            end
            RDONE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // FIFO storage; only the pointers and occupancy define which entries are live.
    always_ff @(posedge Clock) begin
        // NOTE: the entry array is deliberately not reset; clearing r_count discards its contents.
        if (w_push) begin
            r_addr_q[r_tail] <= Daddress;
            r_data_q[r_tail] <= Dout;
        end
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Memory request registers, held stable from request start until the ack edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_start_write) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr_q[r_head];
            r_mem_wdata <= r_data_q[r_head];
        end else if (w_start_read) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= Daddress;
        end else if (w_pop || w_rd_capture) begin
            r_mem_req   <= 1'b0;
        end
    end

    // Read data is captured on the read ack and returned during RDONE.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)            r_rd_data <= '0;
        else if (w_rd_capture) r_rd_data <= mem_rdata;
    end

    // Load data to the processor, updated only when a load is accepted.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)      r_data_in <= '0;
        else if (w_load) r_data_in <= w_hit ? w_hit_data : r_rd_data;
    end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: stimulus pushes expected memory
// transactions and load data into queues; a memory model and a load monitor
// pop and compare as the DUT presents requests and accepted loads.
module tb_mem_write_buffer;

    localparam int DW    = 20;
    localparam int AW    = 20;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_txn_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          W = 1'b0;
    logic          Rd = 1'b0;
    logic [AW-1:0] Daddress = '0;
    logic [DW-1:0] Dout = '0;
    logic [DW-1:0] DataIn;
    logic          Stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] count;

    mem_txn_t      exp_mem[$];
    logic [DW-1:0] exp_load[$];

    int            ack_delay = 0;
    bit            ack_block = 1'b0;
    logic [DW-1:0] rd_value  = '0;
    int            rd_acks   = 0;
    int            n_cmp     = 0;
    int            n_fail    = 0;

    mem_write_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .W         (W),
        .Rd        (Rd),
        .Daddress  (Daddress),
        .Dout      (Dout),
        .DataIn    (DataIn),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .count     (count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_txn_t t;
        t.we   = we;
        t.addr = a;
        t.data = we ? d : '0;
        exp_mem.push_back(t);
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        @(negedge Clock);
        W = 1'b1; Daddress = a; Dout = d;
        #1;
        while (Stall && n < 100) begin
            @(negedge Clock); #1;
            n++;
        end
        check("store_accept_timeout", 64'(n >= 100), 0);
        @(posedge Clock); #1;
        W = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                        input int exp_stall, input int exp_reads);
        int n = 0;
        int r0;
        @(negedge Clock);
        Rd = 1'b1; Daddress = a;
        exp_load.push_back(exp_d);
        r0 = rd_acks;
        #1;
        while (Stall && n < 100) begin
            n++;
            @(negedge Clock); #1;
        end
        check("load_stall_cycles", 64'(n), 64'(exp_stall));
        check("load_mem_reads", 64'(rd_acks - r0), 64'(exp_reads));
        @(posedge Clock); #1;
        Rd = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clock);
        while ((count != '0 || mem_req) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check("drain_timeout", 64'(n >= 200), 0);
    endtask

    // Memory model: compares each request against the expected queue when it starts,
    // then acks after ack_delay extra cycles and checks the request was held stable.
    initial begin : mem_model
        int       wait_cnt;
        bit       busy;
        mem_txn_t snap;
        mem_txn_t cur;
        mem_txn_t e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        busy      = 1'b0;
        forever begin
            @(negedge Clock);
            if (!Reset || !mem_req) begin
                mem_ack = 1'b0; mem_rdata = '0; busy = 1'b0; wait_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0; mem_rdata = '0; busy = 1'b0; wait_cnt = 0;
            end else begin
                cur.we   = mem_we;
                cur.addr = mem_addr;
                cur.data = mem_we ? mem_wdata : '0;
                if (!busy) begin
                    busy     = 1'b1;
                    wait_cnt = 0;
                    snap     = cur;
                    check("mem_req_expected", 64'(exp_mem.size() > 0), 1);
                    if (exp_mem.size() > 0) begin
                        e = exp_mem.pop_front();
                        check("mem_txn", 64'(cur), 64'(e));
                    end
                end
                if (!ack_block && wait_cnt >= ack_delay) begin
                    if (wait_cnt > 0) check("mem_hold", 64'(cur), 64'(snap));
                    mem_ack = 1'b1;
                    if (!mem_we) begin
                        rd_acks++;
                        mem_rdata = rd_value;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Load monitor: a load accepted at an edge must present its data after that edge.
    initial begin : load_monitor
        logic          acc;
        logic [DW-1:0] e;
        forever begin
            @(negedge Clock); #2;
            acc = Reset && Rd && !W && !Stall;
            if (acc) begin
                @(posedge Clock); #1;
                check("load_expected", 64'(exp_load.size() > 0), 1);
                if (exp_load.size() > 0) begin
                    e = exp_load.pop_front();
                    check("load_data", 64'(DataIn), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset held with random inputs: everything quiet.
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            W        = 1'($urandom_range(0, 1));
            Rd       = 1'($urandom_range(0, 1));
            Daddress = AW'($urandom);
            Dout     = DW'($urandom);
            #1;
            check("rst_stall", 64'(Stall), 0);
            check("rst_mem_req", 64'(mem_req), 0);
            check("rst_count", 64'(count), 0);
        end
        check("rst_datain", 64'(DataIn), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        @(negedge Clock);
        W = 1'b0; Rd = 1'b0; Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("post_rst_mem_req", 64'(mem_req), 0);
        end

        // Store then drain with a 3-cycle ack wait.
        ack_delay = 3; ack_block = 1'b0;
        expect_mem(1'b1, 20'h00010, 20'h12345);
        store(20'h00010, 20'h12345);
        check("store_count", 64'(count), 1);
        check("store_req_not_yet", 64'(mem_req), 0);
        @(posedge Clock); #1;
        check("drain_req", 64'(mem_req), 1);
        check("drain_we", 64'(mem_we), 1);
        check("drain_addr", 64'(mem_addr), 64'h00010);
        check("drain_wdata", 64'(mem_wdata), 64'h12345);
        wait_idle();
        check("drain_count", 64'(count), 0);

        // Full stall: four stores fill the buffer, the fifth waits for a pop.
        ack_block = 1'b1; ack_delay = 0;
        for (int k = 1; k <= 5; k++) expect_mem(1'b1, AW'(k), DW'(k * 'h1111));
        for (int k = 1; k <= 4; k++) store(AW'(k), DW'(k * 'h1111));
        check("full_count", 64'(count), 4);
        @(negedge Clock);
        W = 1'b1; Daddress = 20'h5; Dout = 20'h05555;
        #1;
        check("full_stall", 64'(Stall), 1);
        ack_block = 1'b0;
        @(negedge Clock); #1;
        check("full_stall_ack_cycle", 64'(Stall), 1);
        check("full_count_ack_cycle", 64'(count), 4);
        @(negedge Clock); #1;
        check("full_after_pop_stall", 64'(Stall), 0);
        check("full_after_pop_count", 64'(count), 3);
        @(posedge Clock); #1;
        W = 1'b0;
        check("full_refill_count", 64'(count), 4);
        wait_idle();

        // Forwarding from the youngest of two matching stores, no memory read.
        ack_block = 1'b1;
        expect_mem(1'b1, 20'h00007, 20'hAAAAA);
        expect_mem(1'b1, 20'h00007, 20'hBBBBB);
        store(20'h00007, 20'hAAAAA);
        store(20'h00007, 20'hBBBBB);
        load(20'h00007, 20'hBBBBB, 0, 0);
        ack_block = 1'b0;
        wait_idle();

        // Load misses on an empty buffer: minimum stall, then one extra ack wait pair.
        ack_delay = 0; rd_value = 20'h3C3C3;
        expect_mem(1'b0, 20'h00020, '0);
        load(20'h00020, 20'h3C3C3, 2, 1);
        ack_delay = 2; rd_value = 20'h4D4D4;
        expect_mem(1'b0, 20'h00021, '0);
        load(20'h00021, 20'h4D4D4, 4, 1);

        // Load miss during a write: write completes, read goes next, second write last.
        ack_block = 1'b1; ack_delay = 0; rd_value = 20'h0F0F0;
        expect_mem(1'b1, 20'h00030, 20'h11111);
        expect_mem(1'b0, 20'h00009, '0);
        expect_mem(1'b1, 20'h00031, 20'h22222);
        store(20'h00030, 20'h11111);
        store(20'h00031, 20'h22222);
        fork
            load(20'h00009, 20'h0F0F0, 5, 1);
            begin
                repeat (2) @(negedge Clock);
                #1 ack_block = 1'b0;
            end
        join
        wait_idle();

        // Ten stores cycling the pointers; memory order must equal store order.
        ack_block = 1'b0; ack_delay = 1;
        for (int i = 0; i < 10; i++) expect_mem(1'b1, AW'('h100 + i), DW'('h50000 + i));
        for (int i = 0; i < 10; i++) store(AW'('h100 + i), DW'('h50000 + i));
        wait_idle();

        // Reset while a read is in flight.
        ack_block = 1'b1; ack_delay = 0;
        expect_mem(1'b0, 20'h00044, '0);
        @(negedge Clock);
        Rd = 1'b1; Daddress = 20'h00044;
        repeat (2) @(negedge Clock);
        #1;
        check("mid_read_req", 64'(mem_req), 1);
        check("mid_read_we", 64'(mem_we), 0);
        Reset = 1'b0; Rd = 1'b0;
        #1;
        check("mid_rst_req", 64'(mem_req), 0);
        check("mid_rst_datain", 64'(DataIn), 0);
        check("mid_rst_stall", 64'(Stall), 0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("post_mid_rst_req", 64'(mem_req), 0);
            check("post_mid_rst_datain", 64'(DataIn), 0);
        end

        // Reset with buffered stores: entries are discarded and never written.
        expect_mem(1'b1, 20'h00061, 20'h61616);
        store(20'h00061, 20'h61616);
        store(20'h00062, 20'h62626);
        check("discard_count_before", 64'(count), 2);
        check("discard_req_before", 64'(mem_req), 1);
        @(negedge Clock); #1;
        Reset = 1'b0;
        #1;
        check("discard_count", 64'(count), 0);
        check("discard_req", 64'(mem_req), 0);
        @(negedge Clock);
        Reset = 1'b1; ack_block = 1'b0;
        repeat (5) @(negedge Clock);
        check("discard_count_after", 64'(count), 0);
        check("mem_queue_drained", 64'(exp_mem.size()), 0);
        check("load_queue_drained", 64'(exp_load.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
